// File: rtl/mdu_if.sv
// Operand/result bundle between the EX stage and the multiply/divide unit.
// The EX stage drives the request side; the MDU returns busy and the HI/LO registers.
interface mdu_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] a;
  logic [31:0] b;
  logic        flush;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, hi, lo
  );
endinterface

// File: rtl/mdu.sv
// Multiply/divide unit owning the architectural HI/LO registers.
// Results are computed in one shot at accept and committed when the fixed-latency countdown expires.
module mdu #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input logic  clk,
  input logic  rst_n,
  mdu_if.slave bus
);

  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  typedef enum logic [2:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6,
    OP_RSVD  = 3'd7
  } op_e;

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [31:0]      r_resHi;
  logic [31:0]      r_resLo;
  logic             r_resValid;

  op_e         w_op;
  logic        w_busy;
  logic        w_accept;
  logic        w_divZero;
  logic        w_divOvf;
  logic [31:0] w_divisorS;
  logic [31:0] w_divisorU;
  logic [31:0] w_quotS;
  logic [31:0] w_remS;
  logic [31:0] w_quotU;
  logic [31:0] w_remU;
  logic [63:0] w_prodS;
  logic [63:0] w_prodU;

  assign w_op     = op_e'(bus.op);
  assign w_busy   = (r_cnt != '0);
  assign w_accept = bus.start && !w_busy && !bus.flush &&
                    (w_op != OP_NONE) && (w_op != OP_RSVD);

  // Zero and overflow divisors are swapped for 1 so the divider never traps;
  // dividing 0x80000000 by 1 yields exactly the required overflow result.
  always_comb begin
    w_divZero  = (bus.b == 32'd0);
    w_divOvf   = (bus.a == 32'h8000_0000) && (bus.b == 32'hFFFF_FFFF);
    w_divisorS = (w_divZero || w_divOvf) ? 32'd1 : bus.b;
    w_divisorU = w_divZero ? 32'd1 : bus.b;
    w_quotS    = $signed(bus.a) / $signed(w_divisorS);
    w_remS     = $signed(bus.a) % $signed(w_divisorS);
    w_quotU    = bus.a / w_divisorU;
    w_remU     = bus.a % w_divisorU;
    w_prodS    = $signed({{32{bus.a[31]}}, bus.a}) * $signed({{32{bus.b[31]}}, bus.b});
    w_prodU    = {32'd0, bus.a} * {32'd0, bus.b};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt      <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_resHi    <= '0;
      r_resLo    <= '0;
      r_resValid <= 1'b0;
    end else if (w_busy) begin
      // Flush beats the final count, so a cancelled result never reaches HI/LO.
      if (bus.flush) begin
        r_cnt      <= '0;
        r_resHi    <= '0;
        r_resLo    <= '0;
        r_resValid <= 1'b0;
      end else if (r_cnt == CNT_W'(1)) begin
        r_cnt      <= '0;
        r_resValid <= 1'b0;
        if (r_resValid) begin
          r_hi <= r_resHi;
          r_lo <= r_resLo;
        end
      end else begin
        r_cnt <= r_cnt - CNT_W'(1);
      end
    end else if (w_accept) begin
      case (w_op)
        OP_MULT: begin
          r_cnt      <= CNT_W'(MUL_CYCLES);
          r_resHi    <= w_prodS[63:32];
          r_resLo    <= w_prodS[31:0];
          r_resValid <= 1'b1;
        end
        OP_MULTU: begin
          r_cnt      <= CNT_W'(MUL_CYCLES);
          r_resHi    <= w_prodU[63:32];
          r_resLo    <= w_prodU[31:0];
          r_resValid <= 1'b1;
        end
        OP_DIV: begin
          r_cnt      <= CNT_W'(DIV_CYCLES);
          r_resHi    <= w_remS;
          r_resLo    <= w_quotS;
          r_resValid <= !w_divZero;
        end
        OP_DIVU: begin
          r_cnt      <= CNT_W'(DIV_CYCLES);
          r_resHi    <= w_remU;
          r_resLo    <= w_quotU;
          r_resValid <= !w_divZero;
        end
        OP_MTHI: r_hi <= bus.a;
        OP_MTLO: r_lo <= bus.a;
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// Directed scoreboard bench for the multiply/divide unit.
// Expected HI/LO pairs are queued at issue and popped when busy falls.
module tb_mdu;

  localparam logic [2:0] OP_MULT  = 3'd1;
  localparam logic [2:0] OP_MULTU = 3'd2;
  localparam logic [2:0] OP_DIV   = 3'd3;
  localparam logic [2:0] OP_DIVU  = 3'd4;
  localparam logic [2:0] OP_MTHI  = 3'd5;
  localparam logic [2:0] OP_MTLO  = 3'd6;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  exp_t sbQ[$];

  always #5 clk = ~clk;

  mdu_if bus ();

  mdu #(
    .MUL_CYCLES(5),
    .DIV_CYCLES(10)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drives one request at a negedge and returns at the negedge after the accepting edge.
  task automatic applyStimulus(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1;
    bus.op    = op;
    bus.a     = a;
    bus.b     = b;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    bus.op    = 3'd0;
  endtask

  task automatic pushExp(input logic [31:0] hi, input logic [31:0] lo);
    exp_t e;
    e.hi = hi;
    e.lo = lo;
    sbQ.push_back(e);
  endtask

  task automatic popAndCheck(input string tag);
    exp_t e;
    if (sbQ.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL %s_scoreboard observed=empty expected=entry", tag);
    end else begin
      e = sbQ.pop_front();
      checkOutput({tag, "_hi"}, bus.hi, e.hi);
      checkOutput({tag, "_lo"}, bus.lo, e.lo);
    end
  endtask

  task automatic waitDone(input string tag, input int expCycles);
    int n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, 32'(n), 32'(expCycles));
    popAndCheck(tag);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.a     = '0;
    bus.b     = '0;
    bus.flush = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_hi", bus.hi, 32'd0);
    checkOutput("reset_lo", bus.lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] reset during multiply");
    applyStimulus(OP_MTLO, 32'h55, 32'd0);
    checkOutput("preload_lo", bus.lo, 32'h55);
    applyStimulus(OP_MULT, 32'd3, 32'd4);
    @(negedge clk);
    checkOutput("midmul_busy", 32'(bus.busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("asyncrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("asyncrst_hi", bus.hi, 32'd0);
    checkOutput("asyncrst_lo", bus.lo, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    checkOutput("postrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("postrst_hi", bus.hi, 32'd0);
    checkOutput("postrst_lo", bus.lo, 32'd0);

    $display("[TB] multiplies");
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFE);
    applyStimulus(OP_MULT, 32'hFFFF_FFFF, 32'd2);
    waitDone("mult_neg1x2", 5);
    pushExp(32'h0000_0001, 32'hFFFF_FFFE);
    applyStimulus(OP_MULTU, 32'hFFFF_FFFF, 32'd2);
    waitDone("multu_ffx2", 5);

    $display("[TB] divides");
    pushExp(32'hFFFF_FFFF, 32'hFFFF_FFFD);
    applyStimulus(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    waitDone("div_m7by2", 10);
    pushExp(32'h0000_0001, 32'hFFFF_FFFD);
    applyStimulus(OP_DIV, 32'd7, 32'hFFFF_FFFE);
    waitDone("div_7bym2", 10);
    pushExp(32'd1, 32'd3);
    applyStimulus(OP_DIVU, 32'd7, 32'd2);
    waitDone("divu_7by2", 10);

    $display("[TB] divide corner cases");
    applyStimulus(OP_MTHI, 32'h11, 32'd0);
    checkOutput("mthi_busy", 32'(bus.busy), 32'd0);
    checkOutput("mthi_hi", bus.hi, 32'h11);
    checkOutput("mthi_lo", bus.lo, 32'd3);
    applyStimulus(OP_MTLO, 32'h22, 32'd0);
    checkOutput("mtlo_busy", 32'(bus.busy), 32'd0);
    checkOutput("mtlo_hi", bus.hi, 32'h11);
    checkOutput("mtlo_lo", bus.lo, 32'h22);
    pushExp(32'h11, 32'h22);
    applyStimulus(OP_DIV, 32'd100, 32'd0);
    waitDone("div_by0", 10);
    pushExp(32'd0, 32'h8000_0000);
    applyStimulus(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    waitDone("div_ovf", 10);

    $display("[TB] flush and start while busy");
    applyStimulus(OP_MULTU, 32'd5, 32'd5);
    bus.start = 1'b1;
    bus.op    = OP_MTHI;
    bus.a     = 32'h0000_DEAD;
    repeat (4) @(negedge clk);
    checkOutput("flush_busyBefore", 32'(bus.busy), 32'd1);
    bus.start = 1'b0;
    bus.op    = 3'd0;
    bus.flush = 1'b1;
    @(negedge clk);
    bus.flush = 1'b0;
    checkOutput("flush_busy", 32'(bus.busy), 32'd0);
    checkOutput("flush_hi", bus.hi, 32'd0);
    checkOutput("flush_lo", bus.lo, 32'h8000_0000);
    repeat (6) @(negedge clk);
    checkOutput("flushLater_hi", bus.hi, 32'd0);
    checkOutput("flushLater_lo", bus.lo, 32'h8000_0000);

    $display("[TB] back-to-back");
    pushExp(32'd0, 32'd6);
    applyStimulus(OP_MULT, 32'd2, 32'd3);
    waitDone("b2b_mult", 5);
    applyStimulus(OP_MTLO, 32'd9, 32'd0);
    checkOutput("b2b_mtlo_lo", bus.lo, 32'd9);
    checkOutput("b2b_mtlo_hi", bus.hi, 32'd0);
    checkOutput("b2b_mtlo_busy", 32'(bus.busy), 32'd0);

    checkOutput("scoreboard_drained", 32'(sbQ.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mdu.md
# mdu

Multiply/divide unit beside the ALU in the EX stage, taking the same A/B operands and producing the architectural HI/LO registers for MULT, MULTU, DIV, DIVU, MTHI and MTLO. Multiplies and divides run for a fixed, parameterised number of cycles and hold `busy` until done. The EX-stage hazard logic stalls any MDU instruction or MFHI/MFLO while `busy | start` is high. HI/LO are always readable combinationally for MFHI/MFLO forwarding into the EX result mux.

## Interface
- `MUL_CYCLES`, 5: cycles from accepted multiply to HI/LO update (≥1).
- `DIV_CYCLES`, 10: cycles from accepted divide to HI/LO update (≥1).

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request valid this cycle; sampled with `op`, `a`, `b`.
- `op`  in  3  0 none, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MTHI, 6 MTLO, 7 reserved (treated as none).
- `a`  in  32  rs operand: multiplicand/dividend, or MTHI/MTLO source.
- `b`  in  32  rt operand: multiplier/divisor.
- `flush`  in  1  cancels the in-flight operation and any same-cycle `start`.
- `busy`  out  1  registered; high while a multiply/divide is in flight.
- `hi`  out  32  current HI register.
- `lo`  out  32  current LO register.

## Operation
- State: `hi_q`, `lo_q`, countdown `cnt`, pending result `res_hi`/`res_lo`, `busy = (cnt != 0)`.
- Reset: `hi`=0, `lo`=0, `busy`=0, `cnt`=0, pending result cleared.
- Accept rule: `start & ~busy & ~flush` with op 1–6 is accepted. A `start` while `busy` is ignored. The hazard logic must never issue one, and the bench checks it has no effect.
- Multiply and divide are computed from operands latched at accept into `res_hi`/`res_lo`. Either one-shot or iterative arithmetic is acceptable, as long as the result is complete by the final count.
- MULT: 64-bit signed product of `a`×`b`. MULTU: unsigned product. HI = [63:32], LO = [31:0].
- DIV/DIVU: LO = quotient, HI = remainder. Signed divide truncates toward zero, and the remainder takes the sign of the dividend.
- Signed overflow 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
- Divisor 0: the full `DIV_CYCLES` still elapse, and HI/LO are left unchanged.
- MTHI/MTLO: write `a` to HI/LO at the accepting edge. `busy` is not raised.
- Flush: `cnt` is cleared to 0 at the next edge and the pending result is discarded. HI/LO keep their values. `flush` and the final count in the same cycle: flush wins, and HI/LO are not written.
- The divider never raises an exception. Overflow reporting stays with the ALU.

## Timing
- Accept at edge k with latency N (`MUL_CYCLES` or `DIV_CYCLES`): `cnt` loads N at k, then decrements each edge.
- `busy` is high in the cycles after edges k … k+N−1.
- HI/LO update at edge k+N, the same edge at which `busy` falls. They are visible in the first cycle `busy` is low.
- MTHI/MTLO accepted at edge k: new value visible at `hi`/`lo` immediately after edge k.
- Back-to-back: a new `start` in the first cycle `busy` is low is accepted, with zero bubble.
- `rst_n` low mid-operation clears everything immediately (asynchronous). No write occurs on release.
- `hi`/`lo` are pure register outputs. There is no combinational path from `a`, `b` or `start`.

## Test plan
- Reset mid-multiply: MULT 3×4, drop `rst_n` while `busy` → `busy`=0, `hi`=`lo`=0 immediately, and they stay 0 after release.
- MULT a=0xFFFFFFFF, b=2 → `busy` high exactly 5 cycles, then `hi`=0xFFFFFFFF, `lo`=0xFFFFFFFE. MULTU with the same operands → `hi`=1, `lo`=0xFFFFFFFE.
- DIV a=-7 (0xFFFFFFF9), b=2 → after 10 cycles `lo`=0xFFFFFFFD, `hi`=0xFFFFFFFF. DIVU a=7, b=2 → `lo`=3, `hi`=1.
- Divide corner cases:
  - Preload MTHI 0x11 and MTLO 0x22, each visible the next cycle without `busy`.
  - DIV by 0 → `busy` for 10 cycles, then `hi`=0x11, `lo`=0x22.
  - DIV 0x80000000 / 0xFFFFFFFF → `lo`=0x80000000, `hi`=0.
- Flush: MULTU 5×5, assert `flush` on the cycle `cnt`=1 → `busy` drops, HI/LO unchanged. A `start` held during `busy` is ignored, with no extra result write.
- Back-to-back: MULT 2×3, then MTLO 9 in the first non-busy cycle → `lo`=6 then 9 on consecutive cycles, `hi`=0.
